// File: rtl/time_set_controller.sv
// rtl/time_set_controller.sv - HH:MM set controller driven by short/long press events
//
// Purpose: holds a BCD HH:MM value for the display path. Long presses step
// RUN -> SET_HOUR -> SET_MIN -> RUN (commit). Short presses increment the
// selected field. An inactivity timeout abandons the edit and restores the
// value captured on entry.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high
//   event_code  press code: 0 none, 1 short/repeat, 2 long, 3 treated as 0
//   hour_tens   BCD 0..2
//   hour_ones   BCD 0..9
//   min_tens    BCD 0..5
//   min_ones    BCD 0..9
//   mode        0 RUN, 1 SET_HOUR, 2 SET_MIN
//   blink       blank request for the field selected by mode
//   load        1-cycle commit pulse
module time_set_controller #(
  parameter int TIMEOUT    = 500_000_000,
  parameter int BLINK_HALF = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] event_code,
  output logic [1:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [1:0] mode,
  output logic       blink,
  output logic       load
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  localparam logic [29:0] T_LAST = 30'(TIMEOUT - 1);
  localparam logic [23:0] B_LAST = 24'(BLINK_HALF - 1);

  state_t      state, state_n;
  logic [1:0]  ht_n, snap_ht, snap_ht_n;
  logic [3:0]  ho_n, snap_ho, snap_ho_n;
  logic [2:0]  mt_n, snap_mt, snap_mt_n;
  logic [3:0]  mo_n, snap_mo, snap_mo_n;
  logic [29:0] tcnt, tcnt_n;
  logic [23:0] bcnt, bcnt_n;
  logic        blink_n, load_n;
  logic        press, long_press;

  // Code 3 falls through both decodes and behaves like "no event".
  assign press      = (event_code == 2'd1);
  assign long_press = (event_code == 2'd2);
  assign mode       = state;

  always_comb begin
    state_n   = state;
    ht_n      = hour_tens;
    ho_n      = hour_ones;
    mt_n      = min_tens;
    mo_n      = min_ones;
    snap_ht_n = snap_ht;
    snap_ho_n = snap_ho;
    snap_mt_n = snap_mt;
    snap_mo_n = snap_mo;
    tcnt_n    = tcnt;
    bcnt_n    = bcnt;
    blink_n   = blink;
    load_n    = 1'b0;

    case (state)
      RUN: begin
        tcnt_n  = '0;
        bcnt_n  = '0;
        blink_n = 1'b0;
        if (long_press) begin
          state_n   = SET_HOUR;
          snap_ht_n = hour_tens;
          snap_ho_n = hour_ones;
          snap_mt_n = min_tens;
          snap_mo_n = min_ones;
        end
      end

      SET_HOUR, SET_MIN: begin
        if (press || long_press) begin
          // Any activity restarts both the timeout and the blink phase.
          tcnt_n  = '0;
          bcnt_n  = '0;
          blink_n = 1'b0;
          if (press) begin
            if (state == SET_HOUR) begin
              if (hour_tens == 2'd2 && hour_ones == 4'd3) begin
                ht_n = 2'd0;
                ho_n = 4'd0;
              end else if (hour_ones == 4'd9) begin
                ho_n = 4'd0;
                ht_n = hour_tens + 2'd1;
              end else begin
                ho_n = hour_ones + 4'd1;
              end
            end else begin
              if (min_ones == 4'd9) begin
                mo_n = 4'd0;
                mt_n = (min_tens == 3'd5) ? 3'd0 : min_tens + 3'd1;
              end else begin
                mo_n = min_ones + 4'd1;
              end
            end
          end else if (state == SET_HOUR) begin
            state_n = SET_MIN;
          end else begin
            state_n = RUN;
            load_n  = 1'b1;
          end
        end else if (tcnt == T_LAST) begin
          // Abandoned edit: put back the value seen when the edit began.
          state_n = RUN;
          ht_n    = snap_ht;
          ho_n    = snap_ho;
          mt_n    = snap_mt;
          mo_n    = snap_mo;
          tcnt_n  = '0;
          bcnt_n  = '0;
          blink_n = 1'b0;
        end else begin
          tcnt_n = tcnt + 30'd1;
          if (bcnt == B_LAST) begin
            bcnt_n  = '0;
            blink_n = ~blink;
          end else begin
            bcnt_n = bcnt + 24'd1;
          end
        end
      end

      default: begin
        state_n = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      hour_tens <= '0;
      hour_ones <= '0;
      min_tens  <= '0;
      min_ones  <= '0;
      snap_ht   <= '0;
      snap_ho   <= '0;
      snap_mt   <= '0;
      snap_mo   <= '0;
      tcnt      <= '0;
      bcnt      <= '0;
      blink     <= 1'b0;
      load      <= 1'b0;
    end else begin
      state     <= state_n;
      hour_tens <= ht_n;
      hour_ones <= ho_n;
      min_tens  <= mt_n;
      min_ones  <= mo_n;
      snap_ht   <= snap_ht_n;
      snap_ho   <= snap_ho_n;
      snap_mt   <= snap_mt_n;
      snap_mo   <= snap_mo_n;
      tcnt      <= tcnt_n;
      bcnt      <= bcnt_n;
      blink     <= blink_n;
      load      <= load_n;
    end
  end

endmodule

// File: tb/tb_time_set_controller.sv
// tb/tb_time_set_controller.sv - self-checking bench for time_set_controller
module tb_time_set_controller;

  localparam int TO = 100;
  localparam int BH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] event_code = 2'd0;
  logic [1:0] hour_tens;
  logic [3:0] hour_ones;
  logic [2:0] min_tens;
  logic [3:0] min_ones;
  logic [1:0] mode;
  logic       blink;
  logic       load;

  time_set_controller #(.TIMEOUT(TO), .BLINK_HALF(BH)) dut (
    .clk(clk),
    .reset(reset),
    .event_code(event_code),
    .hour_tens(hour_tens),
    .hour_ones(hour_ones),
    .min_tens(min_tens),
    .min_ones(min_ones),
    .mode(mode),
    .blink(blink),
    .load(load)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: time as plain integers, quiet = cycles since last edit activity.
  int m_hour = 0, m_min = 0, m_mode = 0, s_hour = 0, s_min = 0, quiet = 0;
  int m_load = 0;
  bit model_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input int ev, input bit r);
    int e;
    m_load = 0;
    if (r) begin
      m_hour = 0; m_min = 0; m_mode = 0; s_hour = 0; s_min = 0; quiet = 0;
    end else begin
      e = (ev == 3) ? 0 : ev;
      if (m_mode == 0) begin
        if (e == 2) begin
          m_mode = 1; s_hour = m_hour; s_min = m_min; quiet = 0;
        end
      end else if (e == 1) begin
        if (m_mode == 1) m_hour = (m_hour + 1) % 24;
        else             m_min  = (m_min + 1) % 60;
        quiet = 0;
      end else if (e == 2) begin
        if (m_mode == 1) m_mode = 2;
        else begin m_mode = 0; m_load = 1; end
        quiet = 0;
      end else if (quiet == TO - 1) begin
        m_mode = 0; m_hour = s_hour; m_min = s_min; quiet = 0;
      end else begin
        quiet++;
      end
    end
  endtask

  task automatic step(input logic [1:0] ev, input logic r);
    event_code = ev;
    reset = r;
    @(posedge clk);
    model_update(int'(ev), r);
    #1;
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      chk("hour_tens", int'(hour_tens), m_hour / 10);
      chk("hour_ones", int'(hour_ones), m_hour % 10);
      chk("min_tens", int'(min_tens), m_min / 10);
      chk("min_ones", int'(min_ones), m_min % 10);
      chk("mode", int'(mode), m_mode);
      chk("blink", int'(blink), (m_mode == 0) ? 0 : ((quiet / BH) % 2));
      chk("load", int'(load), m_load);
    end
  end

  task automatic lit_time(input string name, input int ht, input int ho,
                          input int mt, input int mo, input int md);
    chk({name, ".ht"}, int'(hour_tens), ht);
    chk({name, ".ho"}, int'(hour_ones), ho);
    chk({name, ".mt"}, int'(min_tens), mt);
    chk({name, ".mo"}, int'(min_ones), mo);
    chk({name, ".mode"}, int'(mode), md);
  endtask

  initial begin
    step(2'd0, 1'b1);
    step(2'd0, 1'b1);
    model_valid = 1'b1;
    lit_time("reset", 0, 0, 0, 0, 0);
    chk("reset.blink", int'(blink), 0);
    chk("reset.load", int'(load), 0);

    // Idle after reset
    repeat (20) step(2'd0, 1'b0);
    lit_time("idle", 0, 0, 0, 0, 0);

    // Hour stepping and 23 -> 00 wrap
    step(2'd2, 1'b0);
    chk("enter_hour.mode", int'(mode), 1);
    for (int i = 1; i <= 23; i++) begin
      step(2'd1, 1'b0);
      if (i == 9)  lit_time("h09", 0, 9, 0, 0, 1);
      if (i == 10) lit_time("h10", 1, 0, 0, 0, 1);
    end
    lit_time("h23", 2, 3, 0, 0, 1);
    step(2'd1, 1'b0);
    lit_time("h_wrap", 0, 0, 0, 0, 1);

    // Minute stepping to 59 then commit
    step(2'd2, 1'b0);
    repeat (59) step(2'd1, 1'b0);
    lit_time("m59", 0, 0, 5, 9, 2);
    step(2'd2, 1'b0);
    lit_time("commit", 0, 0, 5, 9, 0);
    chk("commit.load", int'(load), 1);
    step(2'd0, 1'b0);
    chk("commit.load_drop", int'(load), 0);

    // Timeout restores pre-edit value
    step(2'd2, 1'b0);
    repeat (3) step(2'd1, 1'b0);
    lit_time("h03", 0, 3, 5, 9, 1);
    repeat (99) step(2'd0, 1'b0);
    chk("pre_timeout.mode", int'(mode), 1);
    step(2'd0, 1'b0);
    lit_time("timeout", 0, 0, 5, 9, 0);
    chk("timeout.load", int'(load), 0);

    // Reach SET_MIN at 12:59 and observe blink phase
    step(2'd2, 1'b0);
    repeat (12) step(2'd1, 1'b0);
    step(2'd2, 1'b0);
    lit_time("enter_min", 1, 2, 5, 9, 2);
    for (int i = 1; i <= 12; i++) begin
      step(2'd0, 1'b0);
      if (i == 3)  chk("blink_i3", int'(blink), 0);
      if (i == 4)  chk("blink_i4", int'(blink), 1);
      if (i == 8)  chk("blink_i8", int'(blink), 0);
      if (i == 12) chk("blink_i12", int'(blink), 1);
    end
    step(2'd1, 1'b0);
    lit_time("m_wrap", 1, 2, 0, 0, 2);
    chk("blink_restart", int'(blink), 0);
    for (int i = 1; i <= 4; i++) begin
      step(2'd0, 1'b0);
      if (i == 3) chk("blink_r3", int'(blink), 0);
      if (i == 4) chk("blink_r4", int'(blink), 1);
    end
    repeat (34) step(2'd1, 1'b0);
    lit_time("at_1234", 1, 2, 3, 4, 2);

    // Reset mid-edit, then ignored events
    step(2'd0, 1'b1);
    lit_time("mid_reset", 0, 0, 0, 0, 0);
    chk("mid_reset.blink", int'(blink), 0);
    repeat (5) step(2'd3, 1'b0);
    repeat (3) step(2'd1, 1'b0);
    lit_time("ignored", 0, 0, 0, 0, 0);

    // Event on the expiry cycle wins over the timeout
    step(2'd2, 1'b0);
    repeat (99) step(2'd0, 1'b0);
    step(2'd1, 1'b0);
    lit_time("expiry_press", 0, 1, 0, 0, 1);
    step(2'd2, 1'b0);
    repeat (99) step(2'd0, 1'b0);
    step(2'd2, 1'b0);
    lit_time("expiry_commit", 0, 1, 0, 0, 0);
    chk("expiry_commit.load", int'(load), 1);
    step(2'd0, 1'b0);

    @(posedge clk);
    model_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
